hazard_forward_unit: RTL and testbench

//  Parametrised successor to the pipeline forwarding mux-select logic: per-source-operand forwarding

---
 rtl/hazard_forward_unit.sv | 166 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage operand forwarding selects, load-use stall FSM
// and data-memory freeze control, placed beside the ID/EX register.
// Optional feature macro: HAZARD_PERF_EN adds perf_stall_cnt / perf_fwd_cnt.
module hazard_forward_unit #(
  parameter int NUM_SRC        = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_ex_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs_s,
  input  logic [NUM_SRC-1:0]            id_ex_rs_used,
  input  logic                          ex_mem_valid,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd_s,
  input  logic                          ex_mem_regf_we,
  input  logic                          ex_mem_is_load,
  input  logic [1:0]                    ex_mem_fwd_kind,
  input  logic                          mem_wb_valid,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd_s,
  input  logic                          mem_wb_regf_we,
  input  logic                          dmem_busy,
  input  logic                          flush,
  output logic [NUM_SRC*3-1:0]          fwd_sel,
  output logic                          stall_id,
  output logic                          bubble_ex,
  output logic                          freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_fwd_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Reload value: the first stall cycle is spent in IDLE, the rest are counted here.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYC - 1);

  // EX/MEM result kind -> operand mux select; reserved kind falls back to alu_out.
  function automatic logic [2:0] kind_sel(input logic [1:0] kind);
    case (kind)
      2'd1:    kind_sel = 3'd2;
      2'd2:    kind_sel = 3'd3;
      default: kind_sel = 3'd1;
    endcase
  endfunction

  state_t                  state_p0, state_d, eff_state;
  logic   [2:0]            cnt_p0, cnt_d;
  logic   [NUM_SRC*3-1:0]  fwd_raw;
  logic   [REG_ADDR_W-1:0] rs_c;
  logic                    ex_hit, wb_hit, hazard;
  logic                    stall_raw, bubble_raw, freeze_raw;

  // Per-operand forwarding select and load-use hazard detection.
  always_comb begin
    fwd_raw = '0;
    hazard  = 1'b0;
    rs_c    = '0;
    ex_hit  = 1'b0;
    wb_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_c   = id_ex_rs_s[i*REG_ADDR_W +: REG_ADDR_W];
      ex_hit = ex_mem_valid && ex_mem_regf_we && (ex_mem_rd_s == rs_c);
      wb_hit = mem_wb_valid && mem_wb_regf_we && (mem_wb_rd_s == rs_c);
      if (id_ex_valid && id_ex_rs_used[i] && (rs_c != '0)) begin
        // A load in EX/MEM has no data yet; the stall covers it, so skip to MEM/WB.
        if (ex_hit && !ex_mem_is_load)
          fwd_raw[i*3 +: 3] = kind_sel(ex_mem_fwd_kind);
        else if (wb_hit)
          fwd_raw[i*3 +: 3] = 3'd4;
        if (ex_hit && ex_mem_is_load)
          hazard = 1'b1;
      end
    end
  end

  // Leaving MEM_WAIT behaves as the state that resumes, so the release cycle
  // consumes a pending stall cycle or re-evaluates hazard/flush as IDLE.
  always_comb begin
    eff_state = state_p0;
    if (state_p0 == MEM_WAIT && !dmem_busy)
      eff_state = (cnt_p0 != 3'd0) ? LD_STALL : IDLE;
  end

  // Next-state and Mealy stall/bubble/freeze outputs.
  always_comb begin
    state_d    = state_p0;
    cnt_d      = cnt_p0;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    freeze_raw = 1'b0;
    if (dmem_busy) begin
      freeze_raw = 1'b1;
      stall_raw  = 1'b1;
      state_d    = MEM_WAIT;
    end else begin
      case (eff_state)
        LD_STALL: begin
          if (flush) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (cnt_p0 <= 3'd1) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
            end else begin
              state_d = LD_STALL;
              cnt_d   = cnt_p0 - 3'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          if (hazard && !flush) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = LD_STALL;
              cnt_d   = STALL_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // State and stall-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= 3'd0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
    end
  end

  assign fwd_sel   = rst ? '0 : fwd_raw;
  assign stall_id  = !rst && stall_raw;
  assign bubble_ex = !rst && bubble_raw;
  assign freeze    = !rst && freeze_raw;

`ifdef HAZARD_PERF_EN
  // Performance counters, held while the pipeline is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_fwd_cnt   <= 32'd0;
    end else if (!freeze) begin
      if (stall_id)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (|fwd_sel)
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding selects, load-use
// stall sequencing, flush/freeze priority and async reset.
module tb_hazard_forward_unit;

  localparam int NS = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_ex_valid;
  logic [NS*AW-1:0] id_ex_rs_s;
  logic [NS-1:0] id_ex_rs_used;
  logic          ex_mem_valid;
  logic [AW-1:0] ex_mem_rd_s;
  logic          ex_mem_regf_we;
  logic          ex_mem_is_load;
  logic [1:0]    ex_mem_fwd_kind;
  logic          mem_wb_valid;
  logic [AW-1:0] mem_wb_rd_s;
  logic          mem_wb_regf_we;
  logic          dmem_busy;
  logic          flush;
  logic [NS*3-1:0] fwd_sel;
  logic          stall_id;
  logic          bubble_ex;
  logic          freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_fwd_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  hazard_forward_unit #(
    .NUM_SRC(NS), .REG_ADDR_W(AW), .LOAD_STALL_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .id_ex_valid(id_ex_valid), .id_ex_rs_s(id_ex_rs_s), .id_ex_rs_used(id_ex_rs_used),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rd_s(ex_mem_rd_s), .ex_mem_regf_we(ex_mem_regf_we),
    .ex_mem_is_load(ex_mem_is_load), .ex_mem_fwd_kind(ex_mem_fwd_kind),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd_s(mem_wb_rd_s), .mem_wb_regf_we(mem_wb_regf_we),
    .dmem_busy(dmem_busy), .flush(flush),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .bubble_ex(bubble_ex), .freeze(freeze)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall_id, bubble_ex, freeze in one go
  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
    chk({tag, "_stall"},  32'(stall_id),  32'(s));
    chk({tag, "_bubble"}, 32'(bubble_ex), 32'(b));
    chk({tag, "_freeze"}, 32'(freeze),    32'(f));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_ex_valid = 1'b0; id_ex_rs_s = '0; id_ex_rs_used = '0;
    ex_mem_valid = 1'b0; ex_mem_rd_s = '0; ex_mem_regf_we = 1'b0;
    ex_mem_is_load = 1'b0; ex_mem_fwd_kind = 2'd0;
    mem_wb_valid = 1'b0; mem_wb_rd_s = '0; mem_wb_regf_we = 1'b0;
    dmem_busy = 1'b0; flush = 1'b0;
  endtask

  task automatic set_id(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [1:0] used);
    id_ex_valid = 1'b1; id_ex_rs_s = {rs2, rs1}; id_ex_rs_used = used;
  endtask

  task automatic set_ex(input logic [AW-1:0] rd, input logic ld, input logic [1:0] kind);
    ex_mem_valid = 1'b1; ex_mem_rd_s = rd; ex_mem_regf_we = 1'b1;
    ex_mem_is_load = ld; ex_mem_fwd_kind = kind;
  endtask

  task automatic set_wb(input logic [AW-1:0] rd);
    mem_wb_valid = 1'b1; mem_wb_rd_s = rd; mem_wb_regf_we = 1'b1;
  endtask

  initial begin
    // Reset: a forwarding match and a load hazard present, all outputs still 0
    rst = 1'b1;
    clear_in();
    set_id(5'd3, 5'd5, 2'b11); set_ex(5'd3, 1'b1, 2'd0); set_wb(5'd5);
    #1;
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    clear_in();
    #1;
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);

    // 1: add rd=5 in EX/MEM, rs1=5 -> alu_out
    set_id(5'd5, 5'd0, 2'b01); set_ex(5'd5, 1'b0, 2'd0);
    #1;
    chk("t1_fwd", 32'(fwd_sel), 32'h01);
    chk_ctl("t1", 1'b0, 1'b0, 1'b0);

    // 2: slti rd=7 in EX/MEM and rd=7 in MEM/WB, rs2=7 -> br_en (EX/MEM wins)
    step(); clear_in();
    set_id(5'd1, 5'd7, 2'b11); set_ex(5'd7, 1'b0, 2'd1); set_wb(5'd7);
    #1;
    chk("t2_fwd_bren", 32'(fwd_sel), 32'h10);
    ex_mem_fwd_kind = 2'd2;
    #1;
    chk("t2_fwd_uimm", 32'(fwd_sel), 32'h18);
    ex_mem_fwd_kind = 2'd3;
    #1;
    chk("t2_fwd_rsvd", 32'(fwd_sel), 32'h08);
    ex_mem_regf_we = 1'b0;
    #1;
    chk("t2_fwd_wb_only", 32'(fwd_sel), 32'h20);
    set_wb(5'd1); ex_mem_regf_we = 1'b1; ex_mem_fwd_kind = 2'd0;
    #1;
    chk("t2_fwd_both_ops", 32'(fwd_sel), 32'h0c);

    // 3: lw rd=3, rs1=3 -> two stall/bubble cycles, then MEM/WB forward
    step(); clear_in();
    set_id(5'd3, 5'd0, 2'b01); set_ex(5'd3, 1'b1, 2'd0);
    #1;
    chk("t3_fwd_load", 32'(fwd_sel), 32'h00);
    chk_ctl("t3_c1", 1'b1, 1'b1, 1'b0);
    step();
    chk_ctl("t3_c2", 1'b1, 1'b1, 1'b0);
    step();
    ex_mem_valid = 1'b0; set_wb(5'd3);
    #1;
    chk_ctl("t3_c3", 1'b0, 1'b0, 1'b0);
    chk("t3_fwd_wb", 32'(fwd_sel), 32'h04);

    // 3b: back-to-back dependent load re-stalls from IDLE
    set_ex(5'd3, 1'b1, 2'd0);
    #1;
    chk_ctl("t3b", 1'b1, 1'b1, 1'b0);
    step(); step(); clear_in();

    // 4: register 0 never forwards or stalls; unused operand never stalls
    set_id(5'd0, 5'd9, 2'b01); set_ex(5'd0, 1'b0, 2'd0);
    #1;
    chk("t4_fwd_zero", 32'(fwd_sel), 32'h00);
    ex_mem_is_load = 1'b1;
    #1;
    chk_ctl("t4_zero_load", 1'b0, 1'b0, 1'b0);
    set_ex(5'd9, 1'b0, 2'd0);
    #1;
    chk("t4_fwd_unused", 32'(fwd_sel), 32'h00);
    ex_mem_is_load = 1'b1;
    #1;
    chk_ctl("t4_unused_load", 1'b0, 1'b0, 1'b0);
    id_ex_valid = 1'b0; id_ex_rs_used = 2'b11;
    #1;
    chk_ctl("t4_invalid_id", 1'b0, 1'b0, 1'b0);

    // 5: flush beats hazard; dmem_busy freezes mid LD_STALL and the stall resumes
    step(); clear_in();
    set_id(5'd3, 5'd0, 2'b01); set_ex(5'd3, 1'b1, 2'd0); flush = 1'b1;
    #1;
    chk_ctl("t5_flush", 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    #1;
    chk_ctl("t5_hz", 1'b1, 1'b1, 1'b0);
    step();
    dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_ctl($sformatf("t5_busy%0d", k), 1'b1, 1'b0, 1'b1);
      step();
    end
    dmem_busy = 1'b0;
    #1;
    chk_ctl("t5_resume", 1'b1, 1'b1, 1'b0);
    step();
    ex_mem_valid = 1'b0;
    #1;
    chk_ctl("t5_done", 1'b0, 1'b0, 1'b0);

    // 5b: busy beats hazard+flush; flush honoured once busy drops
    set_ex(5'd3, 1'b1, 2'd0); flush = 1'b1; dmem_busy = 1'b1;
    #1;
    chk_ctl("t5b_busy", 1'b1, 1'b0, 1'b1);
    step();
    dmem_busy = 1'b0;
    #1;
    chk_ctl("t5b_release", 1'b0, 1'b0, 1'b0);
    step();

    // 5c: flush inside LD_STALL returns to IDLE at once
    flush = 1'b0;
    #1;
    chk_ctl("t5c_hz", 1'b1, 1'b1, 1'b0);
    step();
    flush = 1'b1;
    #1;
    chk_ctl("t5c_flush", 1'b0, 1'b0, 1'b0);
    step();
    clear_in();
    #1;
    chk_ctl("t5c_idle", 1'b0, 1'b0, 1'b0);

    // 6: async reset in the middle of LD_STALL
    set_id(5'd3, 5'd0, 2'b01); set_ex(5'd3, 1'b1, 2'd0);
    step();
    #1;
    chk_ctl("t6_ldstall", 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_ctl("t6_rst", 1'b0, 1'b0, 1'b0);
    chk("t6_rst_fwd", 32'(fwd_sel), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("t6_perf_stall", perf_stall_cnt, 32'd0);
    chk("t6_perf_fwd", perf_fwd_cnt, 32'd0);
`endif
    step();
    clear_in();
    rst = 1'b0;
    #1;
    chk_ctl("t6_after", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
